// File: rtl/accum_drain_pkg.sv
// Shared widths, drain FSM states and the result rounding helper for the
// accumulation-buffer drain path.
package accum_drain_pkg;

  localparam int DATA_W = 16;
  localparam int TAIL_W = 8;
  localparam int RES_W  = DATA_W + TAIL_W;

  // Bits needed to index n entries.
  function automatic int bw(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} drain_state_e;

  // Round half up on the signed msb field and saturate at +max. Adding one
  // to a negative value can never overflow, so only +max needs the clamp.
  function automatic logic [DATA_W-1:0] round_res(input logic [DATA_W-1:0] msb,
                                                  input logic             rbit);
    if (rbit && (msb != {1'b0, {(DATA_W-1){1'b1}}}))
      return msb + DATA_W'(1);
    return msb;
  endfunction

endpackage

// File: rtl/accum_drain_fifo.sv
// Synchronous first-word fall-through FIFO used to re-time RAM read data.
// The writer guarantees no push into a full FIFO unless a pop happens in the
// same cycle, so push is not gated here.
module drain_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr, wr_ptr;
  logic             do_pop;

  assign do_pop = pop && (count != '0);
  assign valid  = (count != '0);
  assign dout   = mem[rd_ptr];

  // Storage needs no reset; valid is derived from count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/accum_drain.sv
// Drain reader for the accumulation buffer store port. Sweeps a window of
// entries, re-times the read data through a credit-limited FWFT FIFO and
// streams beats out on valid/ready.
// Build option: define ACCUM_DRAIN_ROUND_EN to round/saturate the result
// field at FIFO write; otherwise the result is the truncated msb field.
module accum_drain
  import accum_drain_pkg::*;
#(
  parameter  int DEPTH  = 256,
  parameter  int BATCH  = 32,
  parameter  int RD_LAT = 2,
  parameter  int FIFO_D = 4,
  localparam int ADDR_W = bw(DEPTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic [ADDR_W:0]           len,
  output logic                      busy,
  output logic                      done,
  output logic [ADDR_W-1:0]         rd_addr,
  input  logic [BATCH*RES_W-1:0]    rd_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BATCH*DATA_W-1:0]   out_data,
  output logic [BATCH*TAIL_W-1:0]   out_tail,
  output logic                      out_last
);
  localparam int FW = BATCH*(DATA_W+TAIL_W) + 1;
  localparam int CW = $clog2(FIFO_D) + 1;
  localparam int LW = ADDR_W + 1;
  localparam int SW = bw(FIFO_D + RD_LAT + 2) + 1;

  drain_state_e          state;
  logic [ADDR_W-1:0]     next_addr;
  logic [LW-1:0]         left;
  logic [RD_LAT:0]       vld_pipe, last_pipe;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_valid, pop, issue;
  logic [FW-1:0]         fifo_din, fifo_dout;
  logic [SW-1:0]         in_flight, occ;
  logic [BATCH*DATA_W-1:0] data_all;
  logic [BATCH*TAIL_W-1:0] tail_all;

  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(DEPTH-1)) ? '0 : a + ADDR_W'(1);
  endfunction

  // Credit: reads in flight plus FIFO occupancy, less a pop happening this
  // cycle (its slot is free by the time any new read lands).
  always_comb begin
    in_flight = '0;
    for (int k = 0; k <= RD_LAT; k++) in_flight = in_flight + SW'(vld_pipe[k]);
    occ   = in_flight + SW'(fifo_count) - SW'(pop);
    issue = (state == RUN) && (occ < SW'(FIFO_D));
  end

  assign pop = fifo_valid && out_ready;

  // Sweep control: address generation, busy/done and state sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_addr   <= '0;
      next_addr <= '0;
      left      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          next_addr <= base_addr;
          left      <= len;
          busy      <= 1'b1;
          if (len == '0) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= RUN;
          end
        end
        RUN: if (issue) begin
          rd_addr   <= next_addr;
          next_addr <= addr_inc(next_addr);
          left      <= left - LW'(1);
          if (left == LW'(1)) state <= FLUSH;
        end
        FLUSH: if (occ == '0) begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Read-latency delay line: marks which cycles carry valid rd_data.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe  <= '0;
      last_pipe <= '0;
    end else begin
      vld_pipe  <= {vld_pipe[RD_LAT-1:0], issue};
      last_pipe <= {last_pipe[RD_LAT-1:0], issue && (left == LW'(1))};
    end
  end

  // Split each word into result and tail; rounding happens before the FIFO.
  for (genvar i = 0; i < BATCH; i++) begin : g_word
    logic [RES_W-1:0] w;
    assign w = rd_data[i*RES_W +: RES_W];
`ifdef ACCUM_DRAIN_ROUND_EN
    assign data_all[i*DATA_W +: DATA_W] = round_res(w[RES_W-1:TAIL_W], w[TAIL_W-1]);
`else
    assign data_all[i*DATA_W +: DATA_W] = w[RES_W-1:TAIL_W];
`endif
    assign tail_all[i*TAIL_W +: TAIL_W] = w[TAIL_W-1:0];
  end

  assign fifo_din = {last_pipe[RD_LAT], data_all, tail_all};

  drain_fifo #(.WIDTH(FW), .DEPTH(FIFO_D)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (vld_pipe[RD_LAT]),
    .din   (fifo_din),
    .pop   (pop),
    .dout  (fifo_dout),
    .valid (fifo_valid),
    .count (fifo_count)
  );

  assign out_valid = fifo_valid;
  assign out_last  = fifo_valid & fifo_dout[FW-1];
  assign out_data  = fifo_dout[FW-2 -: BATCH*DATA_W];
  assign out_tail  = fifo_dout[BATCH*TAIL_W-1:0];

endmodule

// File: tb/tb_accum_drain.sv
// Directed bench for accum_drain: RAM model with 2-cycle read latency,
// hand-derived timing checks and per-beat data checks.
module tb_accum_drain;
  import accum_drain_pkg::*;

  localparam int DEPTH = 256, BATCH = 32, RD_LAT = 2, FIFO_D = 4;

  logic                    clk = 1'b0;
  logic                    rst, start, busy, done, out_valid, out_ready, out_last;
  logic [7:0]              base_addr, rd_addr;
  logic [8:0]              len;
  logic [BATCH*RES_W-1:0]  rd_data;
  logic [BATCH*DATA_W-1:0] out_data;
  logic [BATCH*TAIL_W-1:0] out_tail;

  always #5 clk = ~clk;

  accum_drain #(.DEPTH(DEPTH), .BATCH(BATCH), .RD_LAT(RD_LAT), .FIFO_D(FIFO_D)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .len(len),
    .busy(busy), .done(done), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tail(out_tail), .out_last(out_last)
  );

  function automatic logic [RES_W-1:0] ram_word(input logic [7:0] a, input int i);
    if (a == 8'd100 && i == 0) return {16'h7FFF, 8'h80};
    if (a == 8'd100 && i == 1) return {16'h0010, 8'h80};
    if (a == 8'd100 && i == 2) return {16'h8000, 8'hC0};
    return {a, 3'b000, 5'(i), a[0], 5'(i), 2'b01};
  endfunction

  function automatic logic [BATCH*RES_W-1:0] ram_line(input logic [7:0] a);
    logic [BATCH*RES_W-1:0] l;
    for (int i = 0; i < BATCH; i++) l[i*RES_W +: RES_W] = ram_word(a, i);
    return l;
  endfunction

  function automatic logic [BATCH*DATA_W-1:0] exp_data(input logic [7:0] a);
    logic [BATCH*DATA_W-1:0] d;
    logic [RES_W-1:0] w;
    logic [15:0] m;
    for (int i = 0; i < BATCH; i++) begin
      w = ram_word(a, i);
      m = w[23:8];
`ifdef ACCUM_DRAIN_ROUND_EN
      if (w[7] && m != 16'h7FFF) m = m + 16'd1;
`endif
      d[i*DATA_W +: DATA_W] = m;
    end
    return d;
  endfunction

  function automatic logic [BATCH*TAIL_W-1:0] exp_tail(input logic [7:0] a);
    logic [BATCH*TAIL_W-1:0] t;
    logic [RES_W-1:0] w;
    for (int i = 0; i < BATCH; i++) begin
      w = ram_word(a, i);
      t[i*TAIL_W +: TAIL_W] = w[7:0];
    end
    return t;
  endfunction

  // Store-port RAM: address register then data register (2-cycle latency).
  logic [7:0] a1;
  always @(posedge clk) begin
    a1      <= rd_addr;
    rd_data <= ram_line(a1);
  end

  int total = 0, bad = 0;
  int cyc = 0, sc = 0, beats, dones, fv_cyc, lb_cyc, dn_cyc, rmode = 0, cur_len;
  logic [7:0] cur_base;
  logic [7:0] alog [64];
  logic prev_stall = 1'b0, prev_last, seen100;
  logic [BATCH*DATA_W-1:0] prev_data;
  logic [BATCH*TAIL_W-1:0] prev_tail;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // One clock: sample #1 after the edge, drive ready, check beats/holds.
  task automatic step();
    logic [7:0] a;
    @(posedge clk); #1;
    cyc++;
    out_ready = (rmode == 0) ? 1'b1 : ((cyc % 4) == 0);
    if (cyc - sc >= 0 && cyc - sc < 64) alog[cyc-sc] = rd_addr;
    chk("fifo_bound", 512'(dut.u_fifo.count <= 3'(FIFO_D)), 512'(1'b1));
    if (prev_stall) begin
      chk("hold_valid", 512'(out_valid), 512'(1'b1));
      chk("hold_data",  512'(out_data),  512'(prev_data));
      chk("hold_tail",  512'(out_tail),  512'(prev_tail));
      chk("hold_last",  512'(out_last),  512'(prev_last));
    end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_tail  = out_tail;
    prev_last  = out_last;
    if (out_valid && fv_cyc < 0) fv_cyc = cyc - sc;
    if (out_valid && out_ready) begin
      a = 8'(int'(cur_base) + beats);
      chk("no_extra_beat", 512'(beats < cur_len), 512'(1'b1));
      chk("beat_data", 512'(out_data), 512'(exp_data(a)));
      chk("beat_tail", 512'(out_tail), 512'(exp_tail(a)));
      chk("beat_last", 512'(out_last), 512'(beats == cur_len - 1));
      if (a == 8'd100) begin
        seen100 = 1'b1;
        chk("sat_7fff", 512'(out_data[15:0]), 512'(16'h7FFF));
`ifdef ACCUM_DRAIN_ROUND_EN
        chk("round_up", 512'(out_data[31:16]), 512'(16'h0011));
        chk("round_neg", 512'(out_data[47:32]), 512'(16'h8001));
`else
        chk("trunc", 512'(out_data[31:16]), 512'(16'h0010));
        chk("trunc_neg", 512'(out_data[47:32]), 512'(16'h8000));
`endif
      end
      lb_cyc = cyc - sc;
      beats++;
    end
    if (done) begin
      dones++;
      dn_cyc = cyc - sc;
    end
  endtask

  task automatic start_run(input logic [7:0] b, input int l, input int rm);
    cur_base = b; cur_len = l; rmode = rm;
    base_addr = b; len = 9'(l); start = 1'b1;
    beats = 0; dones = 0; fv_cyc = -1; lb_cyc = -1; dn_cyc = -1;
    sc = cyc + 1; prev_stall = 1'b0;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (dones == 0 && n < budget) begin
      step();
      n++;
    end
    chk("done_timeout", 512'(dones != 0), 512'(1'b1));
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; len = '0; out_ready = 1'b1;
    beats = 0; dones = 0; fv_cyc = -1; cur_len = 0; cur_base = '0; seen100 = 1'b0;
    repeat (3) step();
    chk("rst_busy",  512'(busy),      512'(1'b0));
    chk("rst_done",  512'(done),      512'(1'b0));
    chk("rst_valid", 512'(out_valid), 512'(1'b0));
    chk("rst_last",  512'(out_last),  512'(1'b0));
    chk("rst_addr",  512'(rd_addr),   512'(8'd0));
    rst = 1'b0;
    step();

    // 1: base 0, len 8, always ready
    start_run(8'd0, 8, 0);
    wait_done(60);
    chk("t1_beats",   512'(beats),  512'(8));
    chk("t1_latency", 512'(fv_cyc), 512'(RD_LAT + 2));
    chk("t1_lastcyc", 512'(lb_cyc), 512'(11));
    chk("t1_donecyc", 512'(dn_cyc), 512'(12));
    chk("t1_busy_dn", 512'(busy),   512'(1'b1));
    step();
    chk("t1_busy_lo", 512'(busy),   512'(1'b0));
    chk("t1_done_lo", 512'(done),   512'(1'b0));

    // 2: wrap past DEPTH-1
    start_run(8'd253, 6, 0);
    wait_done(60);
    chk("t2_beats", 512'(beats), 512'(6));
    chk("t2_a0", 512'(alog[1]), 512'(8'd253));
    chk("t2_a1", 512'(alog[2]), 512'(8'd254));
    chk("t2_a2", 512'(alog[3]), 512'(8'd255));
    chk("t2_a3", 512'(alog[4]), 512'(8'd0));
    chk("t2_a4", 512'(alog[5]), 512'(8'd1));
    chk("t2_a5", 512'(alog[6]), 512'(8'd2));
    step();

    // 3: stalled consumer, 1 on / 3 off
    start_run(8'd40, 16, 1);
    wait_done(300);
    chk("t3_beats", 512'(beats), 512'(16));
    rmode = 0;
    step();

    // 4a: zero-length sweep
    start_run(8'd7, 0, 0);
    wait_done(10);
    chk("t4_zero_beats", 512'(beats),  512'(0));
    chk("t4_zero_novld", 512'(fv_cyc), 512'(-1));
    chk("t4_zero_donec", 512'(dn_cyc), 512'(0));
    step();

    // 4b: start during RUN ignored
    start_run(8'd10, 8, 0);
    step();
    base_addr = 8'd200; len = 9'd3; start = 1'b1;
    step();
    start = 1'b0;
    wait_done(60);
    chk("t4_ign_beats", 512'(beats), 512'(8));
    chk("t4_ign_dones", 512'(dones), 512'(1));
    repeat (3) step();
    chk("t4_idle_busy", 512'(busy), 512'(1'b0));

    // 5: rounding / saturation words at entry 100
    start_run(8'd99, 3, 0);
    wait_done(60);
    chk("t5_beats", 512'(beats),   512'(3));
    chk("t5_seen",  512'(seen100), 512'(1'b1));
    step();

    // 6: reset mid-sweep, then a clean sweep
    start_run(8'd0, 8, 0);
    begin
      int n = 0;
      while (beats < 3 && n < 40) begin
        step();
        n++;
      end
    end
    chk("t6_reached3", 512'(beats), 512'(3));
    rst = 1'b1;
    step();
    chk("t6_valid", 512'(out_valid), 512'(1'b0));
    chk("t6_busy",  512'(busy),      512'(1'b0));
    chk("t6_done",  512'(done),      512'(1'b0));
    chk("t6_addr",  512'(rd_addr),   512'(8'd0));
    rst = 1'b0;
    repeat (10) step();
    chk("t6_nodone",  512'(dones), 512'(0));
    chk("t6_nobeats", 512'(beats), 512'(3));
    start_run(8'd5, 8, 0);
    wait_done(60);
    chk("t6_clean_beats", 512'(beats),  512'(8));
    chk("t6_clean_lat",   512'(fv_cyc), 512'(RD_LAT + 2));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
